// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Purpose : Shared constants and types for the instruction fetch stage:
//           datapath width, next-PC select encodings and fetch FSM states.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

   localparam int unsigned XLEN = 32;

   // Next-PC select as driven by decode.
   typedef enum logic [1:0] {
      PCSRC_PC4 = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_JR  = 2'b10,
      PCSRC_J   = 2'b11
   } pcsrc_e;

   // Fetch FSM: REQ issues a request, HOLD parks a fetched word while decode stalls.
   typedef enum logic {
      ST_REQ  = 1'b0,
      ST_HOLD = 1'b1
   } fetch_state_e;

   // Sequential successor address; wraps modulo 2^32.
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instruction_fetch_npc_mux4.sv
// -----------------------------------------------------------------------------
// npc_mux4
// Purpose : 4:1 next-PC selector (sequential, branch, register jump, jump).
// Ports   : sel  [1:0] in   pcsource encoding
//           pc4  [31:0] in  sequential successor
//           bpc, ra, jpc [31:0] in  branch / register / jump targets
//           npc  [31:0] out selected next PC
// -----------------------------------------------------------------------------
module npc_mux4
   import instruction_fetch_pkg::*;
(
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] pc4,
   input  logic [XLEN-1:0] bpc,
   input  logic [XLEN-1:0] ra,
   input  logic [XLEN-1:0] jpc,
   output logic [XLEN-1:0] npc
);

   // Select the next PC; targets are passed through unmodified (no alignment check).
   always_comb begin
      npc = pc4;
      case (pcsrc_e'(sel))
         PCSRC_PC4: npc = pc4;
         PCSRC_BR:  npc = bpc;
         PCSRC_JR:  npc = ra;
         PCSRC_J:   npc = jpc;
         default:   npc = pc4;
      endcase
   end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Purpose : IF stage. Holds the PC, requests instruction words from imem,
//           loads the IF/ID register, parks a fetched word in a hold buffer
//           while decode stalls, and applies decode redirects.
// Ports   : clk, clrn (sync active-high reset)
//           pcsource[1:0], bpc, jpc, ra, stall      from decode
//           imem_req, imem_addr / imem_rdata, imem_ack  instruction memory
//           if_pc4, if_inst, if_valid               IF/ID register
//           fetch_busy                              REQ outstanding without ack
//           perf_fetch_cnt, perf_stall_cnt          only with IF_PERF_CNT_EN
// Config  : define IF_PERF_CNT_EN to add the two wrapping performance counters.
// -----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic            clk,
   input  logic            clrn,
   input  logic [1:0]      pcsource,
   input  logic [XLEN-1:0] bpc,
   input  logic [XLEN-1:0] jpc,
   input  logic [XLEN-1:0] ra,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ack,
   output logic [XLEN-1:0] if_pc4,
   output logic [XLEN-1:0] if_inst,
   output logic            if_valid,
   output logic            fetch_busy
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_stall_cnt
`endif
);

   fetch_state_e    state_r;
   fetch_state_e    state_nxt_s;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] pc4_s;
   logic [XLEN-1:0] mux_pc4_s;
   logic [XLEN-1:0] npc_s;
   logic [XLEN-1:0] hold_inst_r;
   logic [XLEN-1:0] hold_pc4_r;
   logic            redirect_s;
   logic            pc_en_s;
   logic            ifid_load_s;
   logic            ifid_from_hold_s;
   logic            bubble_s;
   logic            hold_load_s;

   assign pc4_s      = pc_plus4(pc_r);
   assign redirect_s = (pcsource != PCSRC_PC4) && !stall;
   assign imem_addr  = pc_r;
   assign imem_req   = (state_r == ST_REQ);
   assign fetch_busy = (state_r == ST_REQ) && !imem_ack;

   // In HOLD the sequential successor is the parked pc+4 (equal to pc+4, but
   // taken from the buffer so the release path mirrors the captured word).
   assign mux_pc4_s  = (state_r == ST_HOLD) ? hold_pc4_r : pc4_s;

   npc_mux4 u_npc_mux4 (
      .sel (pcsource),
      .pc4 (mux_pc4_s),
      .bpc (bpc),
      .ra  (ra),
      .jpc (jpc),
      .npc (npc_s)
   );

   // Next-state and datapath enables for the fetch FSM.
   always_comb begin
      state_nxt_s      = state_r;
      pc_en_s          = 1'b0;
      ifid_load_s      = 1'b0;
      ifid_from_hold_s = 1'b0;
      bubble_s         = 1'b0;
      hold_load_s      = 1'b0;
      case (state_r)
         ST_REQ: begin
            if (redirect_s) begin
               // Any word arriving this cycle belongs to the wrong path.
               pc_en_s  = 1'b1;
               bubble_s = 1'b1;
            end else if (stall) begin
               if (imem_ack) begin
                  hold_load_s = 1'b1;
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end else if (imem_ack) begin
               ifid_load_s = 1'b1;
               pc_en_s     = 1'b1;
            end else begin
               bubble_s = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_s) begin
               // Leaving HOLD abandons the parked word.
               pc_en_s     = 1'b1;
               bubble_s    = 1'b1;
               state_nxt_s = ST_REQ;
            end else if (stall) begin
               state_nxt_s = ST_HOLD;
            end else begin
               ifid_load_s      = 1'b1;
               ifid_from_hold_s = 1'b1;
               pc_en_s          = 1'b1;
               state_nxt_s      = ST_REQ;
            end
         end
         default: begin
            state_nxt_s = ST_REQ;
         end
      endcase
   end

   // FSM state, PC, hold buffer and IF/ID register.
   always_ff @(posedge clk) begin
      if (clrn) begin
         state_r     <= ST_REQ;
         pc_r        <= RESET_PC;
         hold_inst_r <= 32'h0000_0000;
         hold_pc4_r  <= 32'h0000_0000;
         if_pc4      <= 32'h0000_0000;
         if_inst     <= 32'h0000_0000;
         if_valid    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (pc_en_s) begin
            pc_r <= npc_s;
         end
         if (hold_load_s) begin
            hold_inst_r <= imem_rdata;
            hold_pc4_r  <= pc4_s;
         end
         if (ifid_load_s) begin
            if_pc4   <= ifid_from_hold_s ? hold_pc4_r  : pc4_s;
            if_inst  <= ifid_from_hold_s ? hold_inst_r : imem_rdata;
            if_valid <= 1'b1;
         end else if (bubble_s) begin
            if_valid <= 1'b0;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   // Wrapping counters: valid IF/ID loads, and cycles lost to stall or an unacked request.
   always_ff @(posedge clk) begin
      if (clrn) begin
         perf_fetch_cnt <= 32'h0000_0000;
         perf_stall_cnt <= 32'h0000_0000;
      end else begin
         if (ifid_load_s) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (stall || fetch_busy) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
